// File: rtl/cim_pkg.sv
// Shared definitions for the CIM datapath: partial-sum and accumulator
// width derivation, and the accumulator FSM state encoding used by both
// the tile accumulator and the CIM controller.
package cim_pkg;

  // Accumulator FSM states (plain constants so legacy controller code can share them)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_OUTPUT = 2'd2;

  // One crossbar column sums xbar_size products of two datatype_size operands
  function automatic int psum_width_f(input int datatype_size, input int xbar_size);
    return 2 * datatype_size + $clog2(xbar_size);
  endfunction

  // Summing vertical_tiles partial sums needs log2 growth plus one guard bit
  function automatic int acc_width_f(input int psum_width, input int vertical_tiles);
    return psum_width + $clog2(vertical_tiles) + 1;
  endfunction

  // Beat counter must be able to hold vertical_tiles itself once the last beat lands
  function automatic int tile_idx_width_f(input int vertical_tiles);
    return $clog2(vertical_tiles) + 1;
  endfunction

endpackage

// File: rtl/acc_lane.sv
// One signed column accumulator: synchronous clear, add-on-enable of a
// sign-extended partial sum, asynchronous reset to zero.
module acc_lane #(
  parameter int psum_width = 24,
  parameter int acc_width  = 27
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_clear,
  input  logic                         i_en,
  input  logic signed [psum_width-1:0] i_psum,
  output logic signed [acc_width-1:0]  o_acc
);

  logic signed [acc_width-1:0] r_acc;
  logic signed [acc_width-1:0] w_psum_ext;

  assign w_psum_ext = {{(acc_width - psum_width){i_psum[psum_width-1]}}, i_psum};

  // Clear takes priority over accumulate; result is the running column sum
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: accumulator state is reset because o_data must read zero during/after reset.
    if (rst) begin
      r_acc <= '0;
    end else if (i_clear) begin
      // NOTE: non-blocking so every lane samples the same pre-edge state.
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_psum_ext;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/tile_acc.sv
// Tile accumulator: collects vertical_tiles partial-sum beats of num_cols
// columns each, then presents the full-width column sums until taken.
module tile_acc
  import cim_pkg::*;
#(
  parameter int datatype_size  = 8,
  parameter int xbar_size      = 256,
  parameter int vertical_tiles = 2,
  parameter int num_cols       = 4,
  localparam int psum_width    = psum_width_f(datatype_size, xbar_size),
  localparam int acc_width     = acc_width_f(psum_width, vertical_tiles),
  localparam int tidx_width    = tile_idx_width_f(vertical_tiles)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start_acc,
  input  logic                         i_valid,
  input  logic signed [psum_width-1:0] i_psum [num_cols],
  output logic                         o_ready,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic signed [acc_width-1:0]  o_data [num_cols],
  output logic                         o_busy,
  output logic [tidx_width-1:0]        o_tile_idx
);

  localparam logic [tidx_width-1:0] LAST_IDX = tidx_width'(vertical_tiles - 1);

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [tidx_width-1:0] r_tile_idx;
  logic                  w_clear;
  logic                  w_accept;
  logic                  w_last;

  // Start is only honoured from IDLE; beats only consumed in ACCUM
  assign w_clear  = (r_state == ST_IDLE) && i_start_acc;
  assign w_accept = (r_state == ST_ACCUM) && i_valid;
  assign w_last   = w_accept && (r_tile_idx == LAST_IDX);

  // Next-state selection for the IDLE -> ACCUM -> OUTPUT -> IDLE loop
  always_comb begin
    // NOTE: default assignment first so no path leaves w_state_nxt unassigned (no latch).
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (i_start_acc) w_state_nxt = ST_ACCUM;
      ST_ACCUM:  if (w_last)      w_state_nxt = ST_OUTPUT;
      ST_OUTPUT: if (i_ready)     w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Count of beats accepted in the current accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tile_idx <= '0;
    end else if (w_clear) begin
      r_tile_idx <= '0;
    end else if (w_accept) begin
      r_tile_idx <= r_tile_idx + 1'b1;
    end
  end

  // One registered accumulator per column; o_data comes straight from these
  for (genvar c = 0; c < num_cols; c++) begin : g_lane
    acc_lane #(
      .psum_width (psum_width),
      .acc_width  (acc_width)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_clear (w_clear),
      .i_en    (w_accept),
      .i_psum  (i_psum[c]),
      .o_acc   (o_data[c])
    );
  end

  assign o_ready    = (r_state == ST_ACCUM);
  assign o_valid    = (r_state == ST_OUTPUT);
  assign o_busy     = (r_state != ST_IDLE);
  assign o_tile_idx = r_tile_idx;

endmodule

// File: tb/tb_tile_acc.sv
// Self-checking bench for tile_acc: directed corner cases plus randomized
// transactions compared against a plain-arithmetic column-sum model.
module tb_tile_acc;

  localparam int DS = 8;
  localparam int XS = 256;
  localparam int VT = 3;
  localparam int NC = 4;
  localparam int PW = 2 * DS + $clog2(XS);
  localparam int AW = PW + $clog2(VT) + 1;
  localparam int TW = $clog2(VT) + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_start_acc;
  logic                 i_valid;
  logic signed [PW-1:0] i_psum [NC];
  logic                 o_ready;
  logic                 o_valid;
  logic                 i_ready;
  logic signed [AW-1:0] o_data [NC];
  logic                 o_busy;
  logic [TW-1:0]        o_tile_idx;

  int errors = 0;
  int checks = 0;

  // Beats of the current transaction and the stimulus knobs
  longint beats [VT][NC];

  tile_acc #(
    .datatype_size  (DS),
    .xbar_size      (XS),
    .vertical_tiles (VT),
    .num_cols       (NC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start_acc (i_start_acc),
    .i_valid     (i_valid),
    .i_psum      (i_psum),
    .o_ready     (o_ready),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_busy      (o_busy),
    .o_tile_idx  (o_tile_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Advance one clock; inputs and samples both sit 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input int b);
    for (int c = 0; c < NC; c++) i_psum[c] = PW'(beats[b][c]);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"},  longint'(o_busy),     0);
    check({tag, " ready"}, longint'(o_ready),    0);
    check({tag, " valid"}, longint'(o_valid),    0);
  endtask

  task automatic check_data(input string tag);
    longint sum;
    for (int c = 0; c < NC; c++) begin
      sum = 0;
      for (int b = 0; b < VT; b++) sum += beats[b][c];
      check($sformatf("%s col%0d", tag, c), longint'(o_data[c]), sum);
    end
  endtask

  // Full accumulation: start, VT beats with optional gaps, held output, drain
  task automatic run_txn(input string tag, input int gap, input int rdy_delay,
                         input bit stray_start, input bit start_with_valid);
    i_start_acc = 1'b1;
    if (start_with_valid) begin
      i_valid = 1'b1;
      for (int c = 0; c < NC; c++) i_psum[c] = PW'(777 + c);
      check({tag, " idle ready w/ valid"}, longint'(o_ready), 0);
    end
    step();
    i_start_acc = 1'b0;
    i_valid     = 1'b0;
    check({tag, " accum busy"},  longint'(o_busy),     1);
    check({tag, " accum ready"}, longint'(o_ready),    1);
    check({tag, " accum idx0"},  longint'(o_tile_idx), 0);

    for (int b = 0; b < VT; b++) begin
      for (int g = 0; g < gap; g++) begin
        step();
        check({tag, " gap idx"},   longint'(o_tile_idx), b);
        check({tag, " gap valid"}, longint'(o_valid),    0);
      end
      i_valid = 1'b1;
      drive_beat(b);
      if (stray_start && b == 1) i_start_acc = 1'b1;
      step();
      i_valid     = 1'b0;
      i_start_acc = 1'b0;
      check($sformatf("%s idx after beat%0d", tag, b), longint'(o_tile_idx), b + 1);
      check($sformatf("%s valid after beat%0d", tag, b), longint'(o_valid), (b == VT - 1) ? 1 : 0);
    end

    // Hold in OUTPUT while downstream stalls; stray beats must not be taken
    for (int d = 0; d < rdy_delay; d++) begin
      i_valid = 1'b1;
      check({tag, " hold ready"}, longint'(o_ready), 0);
      check_data({tag, " hold"});
      step();
      i_valid = 1'b0;
      check({tag, " hold valid"}, longint'(o_valid),    1);
      check({tag, " hold idx"},   longint'(o_tile_idx), VT);
    end
    check_data(tag);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    check_idle({tag, " drained"});
  endtask

  task automatic set_all(input int b, input longint v);
    for (int c = 0; c < NC; c++) beats[b][c] = v;
  endtask

  initial begin
    rst         = 1'b1;
    i_start_acc = 1'b0;
    i_valid     = 1'b0;
    i_ready     = 1'b0;
    for (int c = 0; c < NC; c++) i_psum[c] = '0;

    #12;
    check_idle("reset");
    check("reset idx", longint'(o_tile_idx), 0);
    for (int c = 0; c < NC; c++) check($sformatf("reset data%0d", c), longint'(o_data[c]), 0);
    rst = 1'b0;
    step();
    step();
    check_idle("post-reset");

    // Basic three-beat accumulation with immediate drain
    for (int c = 0; c < NC; c++) begin
      beats[0][c] = c + 1;
      beats[1][c] = 10 * (c + 1);
      beats[2][c] = -5;
    end
    i_ready = 1'b0;
    run_txn("basic", 0, 1, 1'b0, 1'b0);

    // Most negative partial sum on every beat: must not wrap
    for (int b = 0; b < VT; b++) set_all(b, -(longint'(1) << (PW - 1)));
    run_txn("maxneg", 0, 1, 1'b0, 1'b0);
    for (int b = 0; b < VT; b++) set_all(b, (longint'(1) << (PW - 1)) - 1);
    run_txn("maxpos", 0, 1, 1'b0, 1'b0);

    // Valid gaps and a long downstream stall
    for (int c = 0; c < NC; c++) begin
      beats[0][c] = c + 1;
      beats[1][c] = 10 * (c + 1);
      beats[2][c] = -5;
    end
    run_txn("gaps", 2, 5, 1'b0, 1'b0);

    // Start pulse mid-accumulation is ignored
    run_txn("stray", 0, 1, 1'b1, 1'b0);

    // Valid coincident with start in IDLE is not consumed; idle valid is ignored
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    check_idle("idle valid");
    run_txn("startvalid", 0, 1, 1'b0, 1'b1);

    // Asynchronous reset after two beats, then a clean accumulation
    i_start_acc = 1'b1;
    step();
    i_start_acc = 1'b0;
    for (int b = 0; b < 2; b++) begin
      i_valid = 1'b1;
      for (int c = 0; c < NC; c++) i_psum[c] = PW'(50 + c);
      step();
    end
    i_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_idle("async rst");
    check("async rst idx", longint'(o_tile_idx), 0);
    for (int c = 0; c < NC; c++) check($sformatf("async rst data%0d", c), longint'(o_data[c]), 0);
    step();
    rst = 1'b0;
    step();
    step();
    check_idle("after rst");
    for (int b = 0; b < VT; b++) set_all(b, 1);
    run_txn("ones", 0, 1, 1'b0, 1'b0);

    // Randomized transactions against the column-sum model
    for (int t = 0; t < 40; t++) begin
      logic signed [PW-1:0] v;
      for (int b = 0; b < VT; b++) begin
        for (int c = 0; c < NC; c++) begin
          v = PW'($urandom);
          case ($urandom_range(0, 7))
            0:       beats[b][c] = -(longint'(1) << (PW - 1));
            1:       beats[b][c] = (longint'(1) << (PW - 1)) - 1;
            default: beats[b][c] = longint'(v);
          endcase
        end
      end
      run_txn($sformatf("rand%0d", t), $urandom_range(0, 2), $urandom_range(1, 3),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so a stuck run still terminates with a report
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
